// File: rtl/noc_pkg.sv
// Shared types for the NoC packetizer: FSM states, header layout, byte-keep helpers.
// Used by noc_packetizer; PKT_CHECKSUM_EN selects the optional checksum word.
package noc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PLD,
    CSUM
  } pktz_state_t;

  typedef struct packed {
    logic [7:0]  dest;
    logic [7:0]  src;
    logic [15:0] len;
  } noc_hdr_t;

  localparam logic [3:0] KEEP_ALL = 4'hF;

  function automatic logic [3:0] keep_from_len(input logic [1:0] len_lo);
    logic [3:0] k;
    unique case (len_lo)
      2'd1:    k = 4'h1;
      2'd2:    k = 4'h3;
      2'd3:    k = 4'h7;
      default: k = 4'hF;
    endcase
    return k;
  endfunction

  function automatic logic [31:0] keep_mask(input logic [3:0] keep);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{keep[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/noc_packetizer.sv
// Frames descriptor + payload stream into header-led AXI-Stream NoC packets.
// `define PKT_CHECKSUM_EN appends an XOR checksum word to every packet.
module noc_packetizer
  import noc_pkg::*;
#(
  parameter int TILE_ID_W   = 4,
  parameter int LEN_W       = 16,
  parameter int SRC_TILE_ID = 0
) (
  input  logic                 clk_in,
  input  logic                 clk_in_rst_high,
  input  logic                 desc_valid,
  input  logic [TILE_ID_W-1:0] desc_dest,
  input  logic [LEN_W-1:0]     desc_len,
  output logic                 desc_ready,
  input  logic                 pld_in_TVALID,
  input  logic [31:0]          pld_in_TDATA,
  output logic                 pld_in_TREADY,
  output logic                 stream_out_TVALID,
  output logic [31:0]          stream_out_TDATA,
  output logic [3:0]           stream_out_TKEEP,
  output logic                 stream_out_TLAST,
  input  logic                 stream_out_TREADY,
  output logic [15:0]          pkt_sent_cnt
);

  localparam int WL_W = LEN_W + 1;

  pktz_state_t     state;
  noc_hdr_t        hdr_q;
  logic [WL_W-1:0] words_left;
  logic [WL_W-1:0] words_init;
  logic            beat;
  logic            last_word;
  logic            len_zero;

`ifdef PKT_CHECKSUM_EN
  logic [31:0]     csum_q;
`endif

  assign words_init = (WL_W'(desc_len) + WL_W'(3)) >> 2;
  assign beat       = stream_out_TVALID & stream_out_TREADY;
  assign last_word  = (words_left == WL_W'(1));
  assign len_zero   = (hdr_q.len == 16'd0);
  assign desc_ready = (state == IDLE) & ~clk_in_rst_high;

  // payload words pass straight through; only the header is stored
  always_comb begin
    stream_out_TVALID = 1'b0;
    stream_out_TDATA  = 32'd0;
    stream_out_TKEEP  = KEEP_ALL;
    stream_out_TLAST  = 1'b0;
    pld_in_TREADY     = 1'b0;
    unique case (state)
      HDR: begin
        stream_out_TVALID = 1'b1;
        stream_out_TDATA  = hdr_q;
`ifdef PKT_CHECKSUM_EN
        stream_out_TLAST  = 1'b0;
`else
        stream_out_TLAST  = len_zero;
`endif
      end
      PLD: begin
        stream_out_TVALID = pld_in_TVALID;
        stream_out_TDATA  = pld_in_TDATA;
        pld_in_TREADY     = stream_out_TREADY;
        if (last_word) begin
          stream_out_TKEEP = keep_from_len(hdr_q.len[1:0]);
        end
`ifdef PKT_CHECKSUM_EN
        stream_out_TLAST  = 1'b0;
`else
        stream_out_TLAST  = last_word;
`endif
      end
`ifdef PKT_CHECKSUM_EN
      CSUM: begin
        stream_out_TVALID = 1'b1;
        stream_out_TDATA  = csum_q;
        stream_out_TLAST  = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (clk_in_rst_high) begin
      state        <= IDLE;
      pkt_sent_cnt <= 16'd0;
    end else begin
      if (beat && stream_out_TLAST) begin
        pkt_sent_cnt <= pkt_sent_cnt + 16'd1;
      end
      unique case (state)
        IDLE: begin
          if (desc_valid) begin
            hdr_q <= noc_hdr_t'{
              dest: 8'(desc_dest),
              src:  8'(SRC_TILE_ID),
              len:  16'(desc_len)
            };
            words_left <= words_init;
            state      <= HDR;
          end
        end
        HDR: begin
          if (beat) begin
`ifdef PKT_CHECKSUM_EN
            csum_q <= hdr_q;
            state  <= len_zero ? CSUM : PLD;
`else
            state  <= len_zero ? IDLE : PLD;
`endif
          end
        end
        PLD: begin
          if (beat) begin
            words_left <= words_left - WL_W'(1);
`ifdef PKT_CHECKSUM_EN
            csum_q <= csum_q ^ (pld_in_TDATA & keep_mask(stream_out_TKEEP));
            if (last_word) state <= CSUM;
`else
            if (last_word) state <= IDLE;
`endif
          end
        end
`ifdef PKT_CHECKSUM_EN
        CSUM: begin
          if (beat) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_packetizer.sv
// Directed bench for noc_packetizer (SRC_TILE_ID=1).
// Build with +define+PKT_CHECKSUM_EN to exercise the checksum word.
module tb_noc_packetizer;

  logic        clk_in = 1'b0;
  logic        clk_in_rst_high;
  logic        desc_valid;
  logic [3:0]  desc_dest;
  logic [15:0] desc_len;
  logic        desc_ready;
  logic        pld_in_TVALID;
  logic [31:0] pld_in_TDATA;
  logic        pld_in_TREADY;
  logic        stream_out_TVALID;
  logic [31:0] stream_out_TDATA;
  logic [3:0]  stream_out_TKEEP;
  logic        stream_out_TLAST;
  logic        stream_out_TREADY;
  logic [15:0] pkt_sent_cnt;

  noc_packetizer #(
    .TILE_ID_W   (4),
    .LEN_W       (16),
    .SRC_TILE_ID (1)
  ) dut (
    .clk_in            (clk_in),
    .clk_in_rst_high   (clk_in_rst_high),
    .desc_valid        (desc_valid),
    .desc_dest         (desc_dest),
    .desc_len          (desc_len),
    .desc_ready        (desc_ready),
    .pld_in_TVALID     (pld_in_TVALID),
    .pld_in_TDATA      (pld_in_TDATA),
    .pld_in_TREADY     (pld_in_TREADY),
    .stream_out_TVALID (stream_out_TVALID),
    .stream_out_TDATA  (stream_out_TDATA),
    .stream_out_TKEEP  (stream_out_TKEEP),
    .stream_out_TLAST  (stream_out_TLAST),
    .stream_out_TREADY (stream_out_TREADY),
    .pkt_sent_cnt      (pkt_sent_cnt)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] pw[$];
  logic [31:0] exp_d[$];
  logic [3:0]  exp_k[$];
  logic        exp_l[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic add_exp(input logic [31:0] d, input logic [3:0] k,
                         input logic l);
    exp_d.push_back(d);
    exp_k.push_back(k);
    exp_l.push_back(l);
  endtask

  // with checksum on, TLAST moves to an extra XOR word
  task automatic close_exp();
`ifdef PKT_CHECKSUM_EN
    logic [31:0] x;
    logic [31:0] m;
    x = 32'd0;
    foreach (exp_d[i]) begin
      for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{exp_k[i][b]}};
      x ^= exp_d[i] & m;
    end
    exp_l[exp_l.size()-1] = 1'b0;
    add_exp(x, 4'hF, 1'b1);
`endif
  endtask

  task automatic accept_desc(input string nm, input logic [3:0] dest,
                             input logic [15:0] len);
    bit ok;
    ok = 1'b0;
    desc_valid = 1'b1;
    desc_dest  = dest;
    desc_len   = len;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk_in);
      ok = desc_ready;
      @(posedge clk_in);
      #1;
    end
    desc_valid = 1'b0;
    chk({nm, ".desc_acc"}, 32'(ok), 32'd1);
  endtask

  task automatic send_pkt(input string nm, input logic [3:0] dest,
                          input logic [15:0] len, input bit rnd,
                          input int hold0);
    logic [31:0] rd[$];
    logic [3:0]  rk[$];
    logic        rl[$];
    int          idx;
    int          dr_err;
    int          st_err;
    bit          done;
    bit          hv;
    logic [31:0] hd;
    idx = 0; dr_err = 0; st_err = 0; done = 1'b0; hv = 1'b0; hd = '0;
    accept_desc(nm, dest, len);
    for (int c = 0; c < 800 && !done; c++) begin
      pld_in_TVALID = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pld_in_TDATA  = (idx < pw.size()) ? pw[idx] : 32'hDEAD_BEEF;
      stream_out_TREADY = (c < hold0) ? 1'b0 :
                          (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      @(negedge clk_in);
      if (desc_ready) dr_err++;
      if (hv && stream_out_TVALID && stream_out_TDATA !== hd) st_err++;
      hv = stream_out_TVALID && !stream_out_TREADY;
      hd = stream_out_TDATA;
      if (pld_in_TVALID && pld_in_TREADY) idx++;
      if (stream_out_TVALID && stream_out_TREADY) begin
        rd.push_back(stream_out_TDATA);
        rk.push_back(stream_out_TKEEP);
        rl.push_back(stream_out_TLAST);
        if (stream_out_TLAST) done = 1'b1;
      end
      @(posedge clk_in);
      #1;
    end
    pld_in_TVALID     = 1'b0;
    stream_out_TREADY = 1'b1;
    chk({nm, ".done"}, 32'(done), 32'd1);
    chk({nm, ".pld_taken"}, 32'(idx), 32'(pw.size()));
    chk({nm, ".desc_rdy_busy"}, 32'(dr_err), 32'd0);
    chk({nm, ".hold_stable"}, 32'(st_err), 32'd0);
    chk({nm, ".nwords"}, 32'(rd.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < rd.size(); i++) begin
      chk($sformatf("%s.d%0d", nm, i), rd[i], exp_d[i]);
      chk($sformatf("%s.k%0d", nm, i), 32'(rk[i]), 32'(exp_k[i]));
      chk($sformatf("%s.l%0d", nm, i), 32'(rl[i]), 32'(exp_l[i]));
    end
    pw.delete(); exp_d.delete(); exp_k.delete(); exp_l.delete();
  endtask

  initial begin
    int beats;
    clk_in_rst_high   = 1'b1;
    desc_valid        = 1'b0;
    desc_dest         = '0;
    desc_len          = '0;
    pld_in_TVALID     = 1'b0;
    pld_in_TDATA      = '0;
    stream_out_TREADY = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst.desc_ready", 32'(desc_ready), 32'd0);
    chk("rst.tvalid", 32'(stream_out_TVALID), 32'd0);
    chk("rst.pld_ready", 32'(pld_in_TREADY), 32'd0);
    chk("rst.cnt", 32'(pkt_sent_cnt), 32'd0);
    @(posedge clk_in);
    #1;
    clk_in_rst_high = 1'b0;

    // T1: len=8, two full words
    pw = '{32'hAAAA_0001, 32'hBBBB_0002};
    add_exp(32'h0301_0008, 4'hF, 1'b0);
    add_exp(32'hAAAA_0001, 4'hF, 1'b0);
    add_exp(32'hBBBB_0002, 4'hF, 1'b1);
    close_exp();
    send_pkt("t1", 4'd3, 16'd8, 1'b0, 0);
    chk("t1.cnt", 32'(pkt_sent_cnt), 32'd1);

    // T2: len=5, last word keeps one byte
    pw = '{32'hA5A5_0001, 32'h1234_56EE};
    add_exp(32'h0501_0005, 4'hF, 1'b0);
    add_exp(32'hA5A5_0001, 4'hF, 1'b0);
    add_exp(32'h1234_56EE, 4'h1, 1'b1);
    close_exp();
    send_pkt("t2", 4'd5, 16'd5, 1'b0, 0);
    chk("t2.cnt", 32'(pkt_sent_cnt), 32'd2);

    // T3: header-only; offered payload must never be taken
    add_exp(32'h0701_0000, 4'hF, 1'b1);
    close_exp();
    send_pkt("t3", 4'd7, 16'd0, 1'b0, 0);
    chk("t3.cnt", 32'(pkt_sent_cnt), 32'd3);

    // T4: header held off 3 cycles, then random handshakes, len=64
    add_exp(32'h0901_0040, 4'hF, 1'b0);
    for (int i = 0; i < 16; i++) begin
      pw.push_back(32'h1000_0000 + 32'(i) * 32'h0101_0101);
      add_exp(32'h1000_0000 + 32'(i) * 32'h0101_0101, 4'hF, i == 15);
    end
    close_exp();
    send_pkt("t4", 4'd9, 16'd64, 1'b1, 3);
    chk("t4.cnt", 32'(pkt_sent_cnt), 32'd4);

    // T5: reset pulse at payload word 2 of 4
    accept_desc("t5a", 4'd4, 16'd16);
    beats = 0;
    for (int c = 0; c < 50 && beats < 3; c++) begin
      pld_in_TVALID = 1'b1;
      pld_in_TDATA  = 32'h5500_0000 + 32'(c);
      @(negedge clk_in);
      if (stream_out_TVALID && stream_out_TREADY) beats++;
      @(posedge clk_in);
      #1;
    end
    chk("t5.beats_before_rst", 32'(beats), 32'd3);
    clk_in_rst_high = 1'b1;
    @(negedge clk_in);
    chk("t5.desc_ready_in_rst", 32'(desc_ready), 32'd0);
    @(posedge clk_in);
    #1;
    clk_in_rst_high = 1'b0;
    pld_in_TVALID   = 1'b0;
    @(negedge clk_in);
    chk("t5.tvalid_after", 32'(stream_out_TVALID), 32'd0);
    chk("t5.cnt_after", 32'(pkt_sent_cnt), 32'd0);
    chk("t5.desc_ready_after", 32'(desc_ready), 32'd1);
    @(posedge clk_in);
    #1;
    pw = '{32'hCAFE_F00D};
    add_exp(32'h0401_0004, 4'hF, 1'b0);
    add_exp(32'hCAFE_F00D, 4'hF, 1'b1);
    close_exp();
    send_pkt("t5b", 4'd4, 16'd4, 1'b0, 0);
    chk("t5b.cnt", 32'(pkt_sent_cnt), 32'd1);

`ifdef PKT_CHECKSUM_EN
    // T6: checksum word with partial last word
    pw = '{32'h1122_3344, 32'h5566_AABB};
    add_exp(32'h0201_0006, 4'hF, 1'b0);
    add_exp(32'h1122_3344, 4'hF, 1'b0);
    add_exp(32'h5566_AABB, 4'h3, 1'b0);
    add_exp(32'h0201_0006 ^ 32'h1122_3344 ^ 32'h0000_AABB, 4'hF, 1'b1);
    send_pkt("t6", 4'd2, 16'd6, 1'b0, 0);
    chk("t6.cnt", 32'(pkt_sent_cnt), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
